led_pattern_gen_57: RTL and testbench

Parametrised LED pattern engine for the clock's LED bank. It drives the LED outputs for the alarm, the hourly chime and the game screen. It replaces the fixed 8-LED chase/blink logic with a start/busy/done-controlled sequencer. The sequencer adds width, step and repeat counts, plus two new modes (bounce and fill bar). It sits between the alarm/chime controller, which issues `start_57` and `mode_57`, and the board LED pins.

---
 rtl/led_pkg_57.sv | 42 ++++
 rtl/led_pattern_gen_57_tick_sync.sv | 24 ++
 rtl/led_pattern_gen_57.sv | 154 +++++++++++++++
 tb/tb_led_pattern_gen_57.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg_57.sv
// Shared encodings and step-count helpers for the LED pattern engine.
package led_pkg_57;

   typedef enum logic [1:0] {
      MODE_CHASE  = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_FILL   = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Ticks in one repeat of the given mode.
   function automatic int unsigned STEPS(input mode_e       mode,
                                         input int unsigned led_w,
                                         input int unsigned chase_steps,
                                         input int unsigned blink_steps);
      int unsigned n;
      case (mode)
         MODE_CHASE:  n = chase_steps;
         MODE_BLINK:  n = blink_steps;
         MODE_BOUNCE: n = 2 * led_w - 2;
         default:     n = led_w + 1;
      endcase
      return n;
   endfunction

   function automatic int unsigned max_steps(input int unsigned led_w,
                                             input int unsigned chase_steps,
                                             input int unsigned blink_steps);
      int unsigned m;
      m = chase_steps;
      if (blink_steps > m) m = blink_steps;
      if (2 * led_w - 2 > m) m = 2 * led_w - 2;
      if (led_w + 1 > m) m = led_w + 1;
      return m;
   endfunction

endpackage

// File: rtl/led_pattern_gen_57_tick_sync.sv
// Two-flop synchroniser and rising-edge detector producing a one-cycle tick.
module tick_sync_57 (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_tick
);

   logic [2:0] r_sync;
   logic       r_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= 3'b000;
         r_tick <= 1'b0;
      end else begin
         r_sync <= {r_sync[1:0], i_async};
         r_tick <= r_sync[1] & ~r_sync[2];
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/led_pattern_gen_57.sv
// LED pattern sequencer: chase/blink/bounce/fill runs with start/busy/done,
// plus a free-running game rotator that overrides the display.
module led_pattern_gen_57
   import led_pkg_57::*;
#(
   parameter int unsigned LED_W       = 8,
   parameter int unsigned CHASE_STEPS = 64,
   parameter int unsigned BLINK_STEPS = 8,
   parameter int unsigned REPEATS     = 4
) (
   input  logic             clk_50m_57,
   input  logic             rst_57,
   input  logic             clk_1_57,
   input  logic             game_e_57,
   input  logic             start_57,
   input  logic             stop_57,
   input  logic [1:0]       mode_57,
   output logic             busy_57,
   output logic             done_57,
   output logic [LED_W-1:0] led_w_57
);

   localparam int unsigned MAX_STEPS = max_steps(LED_W, CHASE_STEPS, BLINK_STEPS);
   localparam int unsigned STEP_W    = $clog2(MAX_STEPS);
   localparam int unsigned REP_W     = $clog2(REPEATS) + 1;

   function automatic logic [LED_W-1:0] alt_mask(input logic odd);
      logic [LED_W-1:0] m;
      for (int i = 0; i < int'(LED_W); i++) m[i] = ((i % 2) == 1) == odd;
      return m;
   endfunction

   localparam logic [LED_W-1:0] EVEN_MASK = alt_mask(1'b0);
   localparam logic [LED_W-1:0] ODD_MASK  = alt_mask(1'b1);

   logic              w_tick;
   state_e            r_state;
   mode_e             r_mode;
   logic [STEP_W-1:0] r_step;
   logic [REP_W-1:0]  r_rep;
   logic [LED_W-1:0]  r_pat;
   logic [LED_W-1:0]  r_game;
   logic [LED_W-1:0]  r_led;
   logic              r_busy;
   logic              r_done;

   logic              w_last;
   logic              w_rep_last;
   logic [STEP_W-1:0] w_s;
   logic [STEP_W-1:0] w_pos;
   logic [LED_W:0]    w_fill;
   logic [LED_W-1:0]  w_pat_nxt;
   logic [LED_W-1:0]  w_game_nxt;
   logic [LED_W-1:0]  w_init;

   tick_sync_57 u_tick (
      .clk     (clk_50m_57),
      .rst     (rst_57),
      .i_async (clk_1_57),
      .o_tick  (w_tick)
   );

   // Pattern for the step index that follows the next tick.
   always_comb begin
      w_last     = (r_step == STEP_W'(STEPS(r_mode, LED_W, CHASE_STEPS, BLINK_STEPS) - 1));
      w_rep_last = (r_rep == REP_W'(REPEATS - 1));
      w_s        = w_last ? '0 : r_step + STEP_W'(1);
      w_pos      = (w_s < STEP_W'(LED_W)) ? w_s : STEP_W'(2 * LED_W - 2) - w_s;
      w_fill     = ((LED_W+1)'(1) << w_s) - (LED_W+1)'(1);
      w_pat_nxt  = '0;
      case (r_mode)
         MODE_CHASE:  w_pat_nxt = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
         MODE_BLINK: begin
            if (w_s == STEP_W'(0) || w_s == STEP_W'(2))      w_pat_nxt = EVEN_MASK;
            else if (w_s == STEP_W'(4) || w_s == STEP_W'(6)) w_pat_nxt = ODD_MASK;
            else                                             w_pat_nxt = '0;
         end
         MODE_BOUNCE: w_pat_nxt = LED_W'(1) << w_pos;
         default:     w_pat_nxt = w_fill[LED_W-1:0];
      endcase
      w_game_nxt = (w_tick && game_e_57) ? {r_game[LED_W-2:0], r_game[LED_W-1]} : r_game;
      w_init     = (mode_e'(mode_57) == MODE_CHASE || mode_e'(mode_57) == MODE_BOUNCE)
                   ? LED_W'(1) : '0;
   end

   always_ff @(posedge clk_50m_57 or posedge rst_57) begin
      if (rst_57) r_game <= LED_W'(1);
      else        r_game <= w_game_nxt;
   end

   // Run sequencer; the output register sees next-state values so the
   // display changes in the same cycle as the state it reflects.
   always_ff @(posedge clk_50m_57 or posedge rst_57) begin
      if (rst_57) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_CHASE;
         r_step  <= '0;
         r_rep   <= '0;
         r_pat   <= '0;
         r_led   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (stop_57) begin
            r_state <= ST_IDLE;
            r_pat   <= '0;
            r_busy  <= 1'b0;
            r_led   <= game_e_57 ? w_game_nxt : '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_led <= game_e_57 ? w_game_nxt : '0;
                  if (start_57) begin
                     r_state <= ST_RUN;
                     r_mode  <= mode_e'(mode_57);
                     r_step  <= '0;
                     r_rep   <= '0;
                     r_pat   <= w_init;
                     r_busy  <= 1'b1;
                     r_led   <= game_e_57 ? w_game_nxt : w_init;
                  end
               end
               ST_RUN: begin
                  r_led <= game_e_57 ? w_game_nxt : r_pat;
                  if (w_tick) begin
                     r_step <= w_s;
                     r_pat  <= w_pat_nxt;
                     r_led  <= game_e_57 ? w_game_nxt : w_pat_nxt;
                     if (w_last) begin
                        if (w_rep_last) begin
                           r_state <= ST_IDLE;
                           r_rep   <= '0;
                           r_pat   <= '0;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                           r_led   <= game_e_57 ? w_game_nxt : '0;
                        end else begin
                           r_rep <= r_rep + REP_W'(1);
                        end
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy_57  = r_busy;
   assign done_57  = r_done;
   assign led_w_57 = r_led;

endmodule

// File: tb/tb_led_pattern_gen_57.sv
// Randomised bench for led_pattern_gen_57: an 8-LED default instance and a
// 4-LED single-repeat instance checked against an arithmetic pattern model.
module tb_led_pattern_gen_57;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_1;
   logic       game_e;
   logic       start8;
   logic       start4;
   logic       stop;
   logic [1:0] mode;
   logic       busy8, done8, busy4, done4;
   logic [7:0] led8;
   logic [3:0] led4;

   int nvec = 0;
   int nerr = 0;
   int done8_cnt = 0;
   int done4_cnt = 0;
   int bad_cnt = 0;
   logic pd8 = 1'b0;
   logic pd4 = 1'b0;
   logic [7:0] g8;
   logic [3:0] g4;

   typedef struct {
      int which;
      int m;
      int gf;
      int gt;
      int stop_at;
   } scen_t;

   always #5 clk = ~clk;

   led_pattern_gen_57 dut8 (
      .clk_50m_57 (clk),
      .rst_57     (rst),
      .clk_1_57   (clk_1),
      .game_e_57  (game_e),
      .start_57   (start8),
      .stop_57    (stop),
      .mode_57    (mode),
      .busy_57    (busy8),
      .done_57    (done8),
      .led_w_57   (led8)
   );

   led_pattern_gen_57 #(.LED_W(4), .CHASE_STEPS(8), .BLINK_STEPS(8), .REPEATS(1)) dut4 (
      .clk_50m_57 (clk),
      .rst_57     (rst),
      .clk_1_57   (clk_1),
      .game_e_57  (game_e),
      .start_57   (start4),
      .stop_57    (stop),
      .mode_57    (mode),
      .busy_57    (busy4),
      .done_57    (done4),
      .led_w_57   (led4)
   );

   // Count done pulses; flag ones that overlap busy, stretch, or show LEDs.
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         done8_cnt <= done8_cnt + 1;
         if (busy8 !== 1'b0 || pd8 === 1'b1 || (game_e === 1'b0 && led8 !== 8'h00))
            bad_cnt <= bad_cnt + 1;
      end
      if (done4 === 1'b1) begin
         done4_cnt <= done4_cnt + 1;
         if (busy4 !== 1'b0 || pd4 === 1'b1 || (game_e === 1'b0 && led4 !== 4'h0))
            bad_cnt <= bad_cnt + 1;
      end
      pd8 <= done8;
      pd4 <= done4;
   end

   function automatic int steps_of(input int m, input int w);
      case (m)
         0:       return (w == 8) ? 64 : 8;
         1:       return 8;
         2:       return 2 * w - 2;
         default: return w + 1;
      endcase
   endfunction

   // Display expected k ticks into a run (k >= 1).
   function automatic logic [7:0] model_pat(input int m, input int k, input int w);
      int s;
      int d;
      s = k % steps_of(m, w);
      case (m)
         0: return 8'(1 << (k % w));
         1: begin
            if (s == 0 || s == 2) return (w == 8) ? 8'h55 : 8'h05;
            if (s == 4 || s == 6) return (w == 8) ? 8'hAA : 8'h0A;
            return 8'h00;
         end
         2: begin
            d = (w - 1) - s;
            if (d < 0) d = -d;
            return 8'(1 << ((w - 1) - d));
         end
         default: return 8'((1 << s) - 1);
      endcase
   endfunction

   task automatic obs(input int which, output logic [7:0] l, output logic b,
                      output int dc, output logic [7:0] g);
      if (which == 8) begin
         l = led8; b = busy8; dc = done8_cnt; g = g8;
      end else begin
         l = {4'h0, led4}; b = busy4; dc = done4_cnt; g = {4'h0, g4};
      end
   endtask

   task automatic do_tick();
      clk_1 = 1'b1;
      repeat ($urandom_range(5, 9)) @(posedge clk);
      #1;
      clk_1 = 1'b0;
      repeat ($urandom_range(5, 9)) @(posedge clk);
      #1;
      if (game_e) begin
         g8 = {g8[6:0], g8[7]};
         g4 = {g4[2:0], g4[3]};
      end
   endtask

   task automatic pulse_start(input int which, input int m);
      mode = 2'(m);
      if (which == 8) start8 = 1'b1;
      else            start4 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      start4 = 1'b0;
      mode   = 2'($urandom);
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clk_1 = 1'b0; game_e = 1'b0; start8 = 1'b0; start4 = 1'b0;
      stop = 1'b0; mode = 2'd0; g8 = 8'h01; g4 = 4'h1;
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if (led8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0 ||
          led4 !== 4'h0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
         nerr++;
         $display("FAIL reset: led8=%h busy8=%b done8=%b led4=%h busy4=%b done4=%b, want all 0",
                  led8, busy8, done8, led4, busy4, done4);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         do_tick();
         nvec++;
         if (led8 !== 8'h00 || busy8 !== 1'b0 || done8_cnt !== 0) begin
            nerr++;
            $display("FAIL idle tick %0d: led8=%h busy8=%b dones=%0d, want 00/0/0",
                     i, led8, busy8, done8_cnt);
         end
      end
   endtask

   task automatic test_runs();
      scen_t tbl[$];
      scen_t sc;
      int w, reps, total, dc0, dc, st;
      logic [7:0] l, g, exp;
      logic b;
      bit stopped;
      tbl.push_back('{8, 0, 0, 0, 0});
      tbl.push_back('{8, 1, 0, 0, 0});
      tbl.push_back('{4, 2, 0, 0, 0});
      tbl.push_back('{4, 3, 0, 0, 0});
      tbl.push_back('{8, 2, 0, 0, 0});
      tbl.push_back('{8, 3, 0, 0, 0});
      tbl.push_back('{4, 0, 0, 0, 0});
      tbl.push_back('{4, 1, 0, 0, 0});
      tbl.push_back('{8, 2, 10, 30, 0});
      tbl.push_back('{8, 1, 25, 32, 0});
      tbl.push_back('{8, 3, 0, 0, int'($urandom_range(1, 30))});
      for (int i = 0; i < 4; i++) begin
         sc.which = ($urandom_range(0, 1) == 1) ? 8 : 4;
         sc.m     = int'($urandom_range(0, 3));
         total    = steps_of(sc.m, sc.which) * ((sc.which == 8) ? 4 : 1);
         sc.gf    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, total)) : 0;
         sc.gt    = sc.gf + int'($urandom_range(0, 6));
         sc.stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, total)) : 0;
         tbl.push_back(sc);
      end

      foreach (tbl[i]) begin
         sc    = tbl[i];
         w     = sc.which;
         reps  = (w == 8) ? 4 : 1;
         total = steps_of(sc.m, w) * reps;
         stopped = 1'b0;
         game_e = 1'b0;
         obs(w, l, b, dc0, g);
         pulse_start(w, sc.m);
         obs(w, l, b, dc, g);
         exp = (sc.m == 0 || sc.m == 2) ? 8'h01 : 8'h00;
         nvec++;
         if (b !== 1'b1 || l !== exp) begin
            nerr++;
            $display("FAIL start scen%0d: led=%h busy=%b, want led=%h busy=1", i, l, b, exp);
         end
         for (int k = 1; k <= total; k++) begin
            game_e = (sc.gf != 0 && k >= sc.gf && k <= sc.gt);
            if (k == sc.stop_at) begin
               pulse_stop();
               obs(w, l, b, dc, g);
               exp = game_e ? g : 8'h00;
               nvec++;
               if (b !== 1'b0 || l !== exp || dc !== dc0) begin
                  nerr++;
                  $display("FAIL stop scen%0d k=%0d: led=%h busy=%b dones=%0d, want led=%h busy=0 dones=%0d",
                           i, k, l, b, dc, exp, dc0);
               end
               stopped = 1'b1;
               break;
            end
            do_tick();
            obs(w, l, b, dc, g);
            exp = game_e ? g : ((k < total) ? model_pat(sc.m, k, w) : 8'h00);
            st  = dc0 + ((k == total) ? 1 : 0);
            nvec++;
            if (l !== exp || b !== (k < total) || dc !== st) begin
               nerr++;
               $display("FAIL run scen%0d mode%0d w%0d k=%0d: led=%h busy=%b dones=%0d, want led=%h busy=%b dones=%0d",
                        i, sc.m, w, k, l, b, dc, exp, (k < total), st);
            end
         end
         game_e = 1'b0;
         if (stopped) begin
            do_tick();
            do_tick();
            obs(w, l, b, dc, g);
            nvec++;
            if (l !== 8'h00 || b !== 1'b0 || dc !== dc0) begin
               nerr++;
               $display("FAIL after-stop scen%0d: led=%h busy=%b dones=%0d, want 00/0/%0d",
                        i, l, b, dc, dc0);
            end
         end
      end
   endtask

   task automatic test_start_stop_conflict();
      mode   = 2'd0;
      start8 = 1'b1;
      stop   = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      stop   = 1'b0;
      nvec++;
      if (busy8 !== 1'b0 || led8 !== 8'h00) begin
         nerr++;
         $display("FAIL start+stop: busy8=%b led8=%h, want 0/00", busy8, led8);
      end
   endtask

   task automatic test_async_reset();
      int dc0;
      dc0 = done8_cnt;
      pulse_start(8, 0);
      repeat (3) do_tick();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      nvec++;
      if (led8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0) begin
         nerr++;
         $display("FAIL async reset: led8=%h busy8=%b done8=%b, want 00/0/0", led8, busy8, done8);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      g8 = 8'h01;
      g4 = 4'h1;
      @(posedge clk);
      #1;
      nvec++;
      if (done8_cnt !== dc0) begin
         nerr++;
         $display("FAIL async reset done: dones=%0d, want %0d", done8_cnt, dc0);
      end
      pulse_start(8, 0);
      nvec++;
      if (busy8 !== 1'b1 || led8 !== 8'h01) begin
         nerr++;
         $display("FAIL restart: busy8=%b led8=%h, want 1/01", busy8, led8);
      end
      for (int k = 1; k <= 3; k++) begin
         do_tick();
         nvec++;
         if (led8 !== 8'(1 << k) || busy8 !== 1'b1) begin
            nerr++;
            $display("FAIL restart tick %0d: led8=%h busy8=%b, want %h/1", k, led8, busy8, 8'(1 << k));
         end
      end
      pulse_stop();
      game_e = 1'b1;
      do_tick();
      nvec++;
      if (led8 !== g8 || led4 !== g4) begin
         nerr++;
         $display("FAIL game after reset: led8=%h led4=%h, want %h/%h", led8, led4, g8, g4);
      end
      game_e = 1'b0;
   endtask

   task automatic test_done_pulses();
      nvec++;
      if (bad_cnt !== 0) begin
         nerr++;
         $display("FAIL done pulse shape: bad=%0d, want 0", bad_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_runs();
      test_start_stop_conflict();
      test_async_reset();
      test_done_pulses();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
